// File: rtl/game_pkg.sv
// Shared scene geometry, player physics defaults and the vertical motion state type.
// Imported by the player motion controller and its helpers.
package game_pkg;

    localparam int SCREEN_W  = 640;
    localparam int GRASS_TOP = 384;
    localparam int PLAYER_W  = 32;
    localparam int PLAYER_H  = 32;

    localparam int DEF_RANGE_X  = SCREEN_W - PLAYER_W;
    localparam int DEF_RANGE_Y  = GRASS_TOP - PLAYER_H;
    localparam int DEF_SPEED_X  = 2;
    localparam int DEF_JUMP_V   = 12;
    localparam int DEF_GRAVITY  = 1;
    localparam int DEF_MAX_FALL = 16;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } motion_state_t;

endpackage

// File: rtl/btn_sync.sv
// N-bit two-flop synchronizer for raw asynchronous button levels.
// Latency 2 cycles; no flow control, levels only.
module btn_sync #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] sync_out
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: button-driven horizontal steps plus a jump/gravity FSM.
// Outputs update one cycle after frame_end and hold for the rest of the frame; no backpressure.
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int RANGE_X  = DEF_RANGE_X,
    parameter int RANGE_Y  = DEF_RANGE_Y,
    parameter int SPEED_X  = DEF_SPEED_X,
    parameter int JUMP_V   = DEF_JUMP_V,
    parameter int GRAVITY  = DEF_GRAVITY,
    parameter int MAX_FALL = DEF_MAX_FALL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_jump,
    output logic [9:0]        px,
    output logic [9:0]        py,
    output logic signed [7:0] vy,
    output logic              in_air,
    output logic              landed
);

    localparam logic signed [10:0] SPX      = 11'(SPEED_X);
    localparam logic signed [10:0] RX       = 11'(RANGE_X);
    localparam logic signed [11:0] RY       = 12'(RANGE_Y);
    localparam logic signed [7:0]  JV       = 8'(JUMP_V);
    localparam logic signed [8:0]  GRV      = 9'(GRAVITY);
    localparam logic signed [8:0]  NEG_FALL = 9'(-MAX_FALL);

    logic [2:0]         btn_s;
    logic               left_s, right_s, jump_s;
    logic               jump_armed;
    motion_state_t      state, state_nxt;
    logic [9:0]         px_nxt, py_nxt;
    logic signed [7:0]  vy_nxt;
    logic               landed_nxt;
    logic               launch;
    logic signed [10:0] px_dec, px_inc;
    logic signed [11:0] s;
    logic signed [8:0]  vy_dec;

    btn_sync #(.N(3)) u_btn_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in ({btn_jump, btn_right, btn_left}),
        .sync_out (btn_s)
    );

    assign left_s  = btn_s[0];
    assign right_s = btn_s[1];
    assign jump_s  = btn_s[2];

    // Widened so a step below zero or past the edge saturates instead of wrapping.
    assign px_dec = $signed({1'b0, px}) - SPX;
    assign px_inc = $signed({1'b0, px}) + SPX;
    assign s      = $signed({2'b00, py}) + $signed({{4{vy[7]}}, vy});
    assign vy_dec = $signed({vy[7], vy}) - GRV;

    assign launch = frame_end && (state == GROUND) && jump_s && jump_armed;
    assign in_air = (state == AIR);

    // A launch needs the jump button to have been seen released since the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_armed <= 1'b0;
        end else if (!jump_s) begin
            jump_armed <= 1'b1;
        end else if (launch) begin
            jump_armed <= 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        px_nxt     = px;
        py_nxt     = py;
        vy_nxt     = vy;
        landed_nxt = 1'b0;
        if (frame_end) begin
            if (left_s && !right_s) begin
                px_nxt = (px_dec < 0) ? 10'd0 : px_dec[9:0];
            end else if (right_s && !left_s) begin
                px_nxt = (px_inc > RX) ? RX[9:0] : px_inc[9:0];
            end
            case (state)
                GROUND: begin
                    if (launch) begin
                        vy_nxt    = JV;
                        state_nxt = AIR;
                    end
                end
                AIR: begin
                    if (s <= 0) begin
                        py_nxt     = '0;
                        vy_nxt     = '0;
                        state_nxt  = GROUND;
                        landed_nxt = 1'b1;
                    end else if (s > RY) begin
                        py_nxt = RY[9:0];
                        vy_nxt = '0;
                    end else begin
                        py_nxt = s[9:0];
                        vy_nxt = (vy_dec < NEG_FALL) ? NEG_FALL[7:0] : vy_dec[7:0];
                    end
                end
                default: state_nxt = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= GROUND;
            px     <= '0;
            py     <= '0;
            vy     <= '0;
            landed <= 1'b0;
        end else begin
            state  <= state_nxt;
            px     <= px_nxt;
            py     <= py_nxt;
            vy     <= vy_nxt;
            landed <= landed_nxt;
        end
    end

endmodule
